// File: rtl/rs_alu.sv
// ALU reservation station: buffers issued ALU/branch/jump ops, snoops the CDB and its own
// result bus, dispatches the lowest-index ready entry to the execute unit and broadcasts the result.

module rs_alu_entry #(
    parameter int ROB_W = 4,
    parameter int OP_W  = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             wr,
    input  logic             take,
    input  logic [OP_W-1:0]  new_op,
    input  logic [31:0]      new_vj,
    input  logic [31:0]      new_vk,
    input  logic [31:0]      new_A,
    input  logic [31:0]      new_pc,
    input  logic             new_qj_valid,
    input  logic             new_qk_valid,
    input  logic [ROB_W-1:0] new_qj,
    input  logic [ROB_W-1:0] new_qk,
    input  logic [ROB_W-1:0] new_dest,
    input  logic             cdb_valid,
    input  logic [ROB_W-1:0] cdb_tag,
    input  logic [31:0]      cdb_value,
    input  logic             fwd_valid,
    input  logic [ROB_W-1:0] fwd_tag,
    input  logic [31:0]      fwd_value,
    output logic             busy,
    output logic             ready,
    output logic [OP_W-1:0]  op,
    output logic [31:0]      vj,
    output logic [31:0]      vk,
    output logic [31:0]      A,
    output logic [31:0]      pc,
    output logic [ROB_W-1:0] dest
);
    logic             qj_pend, qk_pend;
    logic [ROB_W-1:0] qj, qk;
    logic [32:0]      j_next, k_next;

    // {pending, value} after looking at both broadcast buses this cycle
    function automatic logic [32:0] snoop(input logic pend, input logic [ROB_W-1:0] tag,
                                          input logic [31:0] val);
        logic [32:0] r;
        r = {pend, val};
        if (pend && cdb_valid && cdb_tag == tag)
            r = {1'b0, cdb_value};
        else if (pend && fwd_valid && fwd_tag == tag)
            r = {1'b0, fwd_value};
        return r;
    endfunction

    always_comb begin
        j_next = wr ? snoop(new_qj_valid, new_qj, new_vj) : snoop(qj_pend, qj, vj);
        k_next = wr ? snoop(new_qk_valid, new_qk, new_vk) : snoop(qk_pend, qk, vk);
    end

    assign ready = busy && !qj_pend && !qk_pend;

    always_ff @(posedge clk) begin
        if (!rst_n || clear)
            busy <= 1'b0;
        else if (wr)
            busy <= 1'b1;
        else if (take)
            busy <= 1'b0;
    end

    // Payload needs no reset: it is only observed while busy.
    always_ff @(posedge clk) begin
        {qj_pend, vj} <= j_next;
        {qk_pend, vk} <= k_next;
        if (wr) begin
            op   <= new_op;
            A    <= new_A;
            pc   <= new_pc;
            dest <= new_dest;
            qj   <= new_qj;
            qk   <= new_qk;
        end
    end
endmodule

module rs_alu #(
    parameter int RS_SIZE = 8,
    parameter int ROB_W   = 4,
    parameter int OP_W    = 6
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             clear_in,
    input  logic             issue_valid,
    input  logic [OP_W-1:0]  issue_op,
    input  logic [31:0]      issue_vj,
    input  logic [31:0]      issue_vk,
    input  logic             issue_qj_valid,
    input  logic             issue_qk_valid,
    input  logic [ROB_W-1:0] issue_qj,
    input  logic [ROB_W-1:0] issue_qk,
    input  logic [31:0]      issue_A,
    input  logic [31:0]      issue_pc,
    input  logic [ROB_W-1:0] issue_dest,
    output logic             rs_full,
    input  logic             cdb_valid,
    input  logic [ROB_W-1:0] cdb_tag,
    input  logic [31:0]      cdb_value,
    output logic [OP_W-1:0]  ex_ordertype,
    output logic [31:0]      ex_vj,
    output logic [31:0]      ex_vk,
    output logic [31:0]      ex_A,
    output logic [31:0]      ex_pc,
    input  logic [31:0]      ex_value,
    input  logic [31:0]      ex_jumppc,
    output logic             out_valid,
    output logic [ROB_W-1:0] out_tag,
    output logic [31:0]      out_value,
    output logic [31:0]      out_jumppc
);
    localparam int IDX_W  = $clog2(RS_SIZE);
    localparam int STAGES = 1;

    logic [RS_SIZE-1:0]            busy, ready, wr, take;
    logic [RS_SIZE-1:0][OP_W-1:0]  ent_op;
    logic [RS_SIZE-1:0][31:0]      ent_vj, ent_vk, ent_A, ent_pc;
    logic [RS_SIZE-1:0][ROB_W-1:0] ent_dest;
    logic [IDX_W-1:0]              free_idx, sel_idx;
    logic                          sel_any;
    logic [STAGES:0]               vld_pipe;
    logic [ROB_W-1:0]              stage_tag;

    for (genvar g = 0; g < RS_SIZE; g++) begin : g_ent
        rs_alu_entry #(.ROB_W(ROB_W), .OP_W(OP_W)) u_ent (
            .clk          (clk_in),
            .rst_n        (rst_n_in),
            .clear        (clear_in),
            .wr           (wr[g]),
            .take         (take[g]),
            .new_op       (issue_op),
            .new_vj       (issue_vj),
            .new_vk       (issue_vk),
            .new_A        (issue_A),
            .new_pc       (issue_pc),
            .new_qj_valid (issue_qj_valid),
            .new_qk_valid (issue_qk_valid),
            .new_qj       (issue_qj),
            .new_qk       (issue_qk),
            .new_dest     (issue_dest),
            .cdb_valid    (cdb_valid),
            .cdb_tag      (cdb_tag),
            .cdb_value    (cdb_value),
            .fwd_valid    (out_valid),
            .fwd_tag      (out_tag),
            .fwd_value    (out_value),
            .busy         (busy[g]),
            .ready        (ready[g]),
            .op           (ent_op[g]),
            .vj           (ent_vj[g]),
            .vk           (ent_vk[g]),
            .A            (ent_A[g]),
            .pc           (ent_pc[g]),
            .dest         (ent_dest[g])
        );
    end

    assign rs_full   = &busy;
    assign out_valid = vld_pipe[STAGES];

    // Downward scan leaves the lowest matching index in place.
    always_comb begin
        free_idx = '0;
        sel_idx  = '0;
        sel_any  = 1'b0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!busy[i])
                free_idx = IDX_W'(i);
            if (ready[i]) begin
                sel_idx = IDX_W'(i);
                sel_any = 1'b1;
            end
        end
        wr            = '0;
        take          = '0;
        wr[free_idx]  = issue_valid && !rs_full && !clear_in;
        take[sel_idx] = sel_any && !clear_in;
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            ex_ordertype <= '0;
            ex_vj        <= '0;
            ex_vk        <= '0;
            ex_A         <= '0;
            ex_pc        <= '0;
            vld_pipe     <= '0;
            stage_tag    <= '0;
            out_tag      <= '0;
            out_value    <= '0;
            out_jumppc   <= '0;
        end else begin
            vld_pipe <= clear_in ? '0 : {vld_pipe[STAGES-1:0], sel_any};
            if (sel_any && !clear_in) begin
                ex_ordertype <= ent_op[sel_idx];
                ex_vj        <= ent_vj[sel_idx];
                ex_vk        <= ent_vk[sel_idx];
                ex_A         <= ent_A[sel_idx];
                ex_pc        <= ent_pc[sel_idx];
                stage_tag    <= ent_dest[sel_idx];
            end
            out_tag    <= stage_tag;
            out_value  <= ex_value;
            out_jumppc <= ex_jumppc;
        end
    end
endmodule

// File: tb/tb_rs_alu.sv
// Scoreboard bench for rs_alu: a small execute-unit model closes the loop, expected
// broadcasts are queued at issue time and a forked monitor pops them on out_valid.

module tb_rs_alu;
    localparam logic [5:0] OP_ADD  = 6'd1;
    localparam logic [5:0] OP_SUB  = 6'd2;
    localparam logic [5:0] OP_XOR  = 6'd3;
    localparam logic [5:0] OP_ADDI = 6'd4;
    localparam logic [5:0] OP_JALR = 6'd5;

    logic        clk_in = 1'b0;
    logic        rst_n_in, clear_in, issue_valid;
    logic [5:0]  issue_op;
    logic [31:0] issue_vj, issue_vk, issue_A, issue_pc;
    logic        issue_qj_valid, issue_qk_valid;
    logic [3:0]  issue_qj, issue_qk, issue_dest;
    logic        rs_full;
    logic        cdb_valid;
    logic [3:0]  cdb_tag;
    logic [31:0] cdb_value;
    logic [5:0]  ex_ordertype;
    logic [31:0] ex_vj, ex_vk, ex_A, ex_pc, ex_value, ex_jumppc;
    logic        out_valid;
    logic [3:0]  out_tag;
    logic [31:0] out_value, out_jumppc;

    typedef struct {
        logic [3:0]  tag;
        logic [31:0] value;
        logic [31:0] jumppc;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    always #5 clk_in = ~clk_in;

    rs_alu #(.RS_SIZE(8), .ROB_W(4), .OP_W(6)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .clear_in(clear_in),
        .issue_valid(issue_valid), .issue_op(issue_op), .issue_vj(issue_vj), .issue_vk(issue_vk),
        .issue_qj_valid(issue_qj_valid), .issue_qk_valid(issue_qk_valid),
        .issue_qj(issue_qj), .issue_qk(issue_qk), .issue_A(issue_A), .issue_pc(issue_pc),
        .issue_dest(issue_dest), .rs_full(rs_full),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .ex_ordertype(ex_ordertype), .ex_vj(ex_vj), .ex_vk(ex_vk), .ex_A(ex_A), .ex_pc(ex_pc),
        .ex_value(ex_value), .ex_jumppc(ex_jumppc),
        .out_valid(out_valid), .out_tag(out_tag), .out_value(out_value), .out_jumppc(out_jumppc)
    );

    // Combinational execute unit
    always_comb begin
        ex_value  = 32'd0;
        ex_jumppc = 32'd0;
        case (ex_ordertype)
            OP_ADD:  ex_value = ex_vj + ex_vk;
            OP_SUB:  ex_value = ex_vj - ex_vk;
            OP_XOR:  ex_value = ex_vj ^ ex_vk;
            OP_ADDI: ex_value = ex_vj + ex_A;
            OP_JALR: begin
                ex_value  = ex_pc + 32'd4;
                ex_jumppc = (ex_vj + ex_A) & ~32'd1;
            end
            default: ex_value = 32'd0;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_in);
        #1;
    endtask

    task automatic push(input logic [3:0] tag, input logic [31:0] value, input logic [31:0] jpc);
        exp_t e;
        e.tag = tag; e.value = value; e.jumppc = jpc;
        sb.push_back(e);
    endtask

    task automatic issue(input logic [5:0] op, input logic [31:0] vj, input logic [31:0] vk,
                         input logic qjv, input logic [3:0] qj, input logic [31:0] a,
                         input logic [31:0] pc, input logic [3:0] dest);
        issue_valid = 1'b1; issue_op = op; issue_vj = vj; issue_vk = vk;
        issue_qj_valid = qjv; issue_qj = qj; issue_qk_valid = 1'b0; issue_qk = 4'd0;
        issue_A = a; issue_pc = pc; issue_dest = dest;
        tick;
        issue_valid = 1'b0;
    endtask

    task automatic broadcast(input logic [3:0] tag, input logic [31:0] value);
        cdb_valid = 1'b1; cdb_tag = tag; cdb_value = value;
        tick;
        cdb_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        for (int c = 0; c < budget && sb.size() != 0; c++) tick;
        tick;
        chk("drain_pending", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        rst_n_in = 1'b0; clear_in = 1'b0; issue_valid = 1'b0; issue_op = '0;
        issue_vj = '0; issue_vk = '0; issue_A = '0; issue_pc = '0;
        issue_qj_valid = 1'b0; issue_qk_valid = 1'b0; issue_qj = '0; issue_qk = '0;
        issue_dest = '0; cdb_valid = 1'b0; cdb_tag = '0; cdb_value = '0;

        fork
            forever begin
                @(negedge clk_in);
                if (out_valid === 1'b1) begin
                    if (sb.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL unexpected_out: got tag %0d value %0h, expected no broadcast",
                                 out_tag, out_value);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        chk("out_tag", 32'(out_tag), 32'(e.tag));
                        chk("out_value", out_value, e.value);
                        chk("out_jumppc", out_jumppc, e.jumppc);
                    end
                end
            end
        join_none

        tick; tick;
        chk("rst_full", 32'(rs_full), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_ex_ordertype", 32'(ex_ordertype), 32'd0);
        chk("rst_ex_vj", ex_vj, 32'd0);
        rst_n_in = 1'b1;
        tick;

        // Ready ADD: dispatch one edge after issue, broadcast one edge later
        push(4'd3, 32'd12, 32'd0);
        issue(OP_ADD, 32'd5, 32'd7, 1'b0, 4'd0, 32'd0, 32'd0, 4'd3);
        tick;
        chk("add_ex_ordertype", 32'(ex_ordertype), 32'(OP_ADD));
        chk("add_ex_vj", ex_vj, 32'd5);
        chk("add_ex_vk", ex_vk, 32'd7);
        tick;
        chk("add_out_valid_hi", 32'(out_valid), 32'd1);
        tick;
        chk("add_out_valid_lo", 32'(out_valid), 32'd0);

        // Dependency chain woken by the station's own broadcast
        push(4'd1, 32'd11, 32'd0);
        push(4'd2, 32'd7, 32'd0);
        issue(OP_ADDI, 32'd10, 32'd0, 1'b0, 4'd0, 32'd1, 32'd0, 4'd1);
        issue(OP_SUB, 32'd0, 32'd4, 1'b1, 4'd1, 32'd0, 32'd0, 4'd2);
        wait_drain(20);

        // Same-cycle bypass from the CDB at issue
        push(4'd6, 32'h0F0F, 32'd0);
        cdb_valid = 1'b1; cdb_tag = 4'd5; cdb_value = 32'hF0F0;
        issue(OP_XOR, 32'd0, 32'hFFFF, 1'b1, 4'd5, 32'd0, 32'd0, 4'd6);
        cdb_valid = 1'b0;
        tick;
        chk("byp_ex_ordertype", 32'(ex_ordertype), 32'(OP_XOR));
        tick;
        chk("byp_out_valid", 32'(out_valid), 32'd1);
        tick;

        // Reset mid-operation drops stalled entries and clears the execute bus
        for (int i = 0; i < 3; i++)
            issue(OP_ADD, 32'd0, 32'd1, 1'b1, 4'd9, 32'd0, 32'd0, 4'(12 + i));
        rst_n_in = 1'b0;
        tick;
        rst_n_in = 1'b1;
        chk("mrst_full", 32'(rs_full), 32'd0);
        chk("mrst_out_valid", 32'(out_valid), 32'd0);
        chk("mrst_ex_ordertype", 32'(ex_ordertype), 32'd0);
        chk("mrst_ex_vj", ex_vj, 32'd0);
        chk("mrst_ex_vk", ex_vk, 32'd0);
        broadcast(4'd9, 32'd50);
        repeat (4) tick;

        // Fill all entries, ninth issue is dropped
        for (int i = 0; i < 8; i++) begin
            push(4'(i), 32'(100 + i), 32'd0);
            issue(OP_ADD, 32'd0, 32'(i), 1'b1, 4'd9, 32'd0, 32'd0, 4'(i));
        end
        chk("full_set", 32'(rs_full), 32'd1);
        issue(OP_ADD, 32'd1, 32'd1, 1'b0, 4'd0, 32'd0, 32'd0, 4'd10);
        chk("full_drop", 32'(rs_full), 32'd1);
        broadcast(4'd9, 32'd100);
        chk("full_after_wake", 32'(rs_full), 32'd1);
        tick;
        chk("full_after_dispatch", 32'(rs_full), 32'd0);
        wait_drain(30);

        // Flush with four stalled entries and one instruction in the stage
        for (int i = 0; i < 4; i++)
            issue(OP_ADD, 32'd0, 32'd1, 1'b1, 4'd9, 32'd0, 32'd0, 4'(12 + i));
        issue(OP_ADD, 32'd1, 32'd1, 1'b0, 4'd0, 32'd0, 32'd0, 4'd11);
        tick;
        clear_in = 1'b1;
        issue(OP_ADD, 32'd2, 32'd2, 1'b0, 4'd0, 32'd0, 32'd0, 4'd10);
        clear_in = 1'b0;
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_full", 32'(rs_full), 32'd0);
        broadcast(4'd9, 32'd77);
        repeat (4) tick;

        // JALR after flush
        push(4'd7, 32'h104, 32'h1004);
        issue(OP_JALR, 32'h1001, 32'd0, 1'b0, 4'd0, 32'd4, 32'h100, 4'd7);
        wait_drain(10);

        repeat (3) tick;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/rs_alu.md
Name: rs_alu

Overview:
- ALU reservation station of the Tomasulo core; the producer side of the combinational ALU execute unit.
- Buffers issued ALU/branch/jump instructions and watches operand tags on the CDB.
- Selects one ready entry per cycle and drives the execute-unit operand bus (ordertype, vj, vk, A, pc) from a register.
- Captures the unit's value/jumppc and broadcasts them with the ROB tag on the ALU result bus, feeding its own wake-up logic.

Parameters:
- RS_SIZE, 8, number of entries (power of two, ≥2).
- ROB_W, 4, ROB tag width.
- OP_W, 6, instruction-type code width (matches INST_TYPE_WIDTH).

Ports:
- clk_in  in  1  clock; all state updates on rising edge.
- rst_n_in  in  1  synchronous active-low reset.
- clear_in  in  1  misprediction flush.
- issue_valid  in  1  issue request.
- issue_op  in  OP_W  instruction type.
- issue_vj, issue_vk  in  32  operand values.
- issue_qj_valid, issue_qk_valid  in  1  operand still pending.
- issue_qj, issue_qk  in  ROB_W  producer tags.
- issue_A  in  32  immediate.
- issue_pc  in  32  instruction pc.
- issue_dest  in  ROB_W  destination ROB tag.
- rs_full  out  1  no free entry.
- cdb_valid  in  1  external (LSB) broadcast valid.
- cdb_tag  in  ROB_W  external broadcast tag.
- cdb_value  in  32  external broadcast value.
- ex_ordertype  out  OP_W  to execute unit.
- ex_vj, ex_vk, ex_A, ex_pc  out  32  to execute unit.
- ex_value, ex_jumppc  in  32  combinational results from execute unit.
- out_valid  out  1  ALU result broadcast valid.
- out_tag  out  ROB_W  ROB tag of result.
- out_value  out  32  result value (branch: taken flag 0/1).
- out_jumppc  out  32  JALR target, else 0.

Behaviour:
- Reset (rst_n_in=0 at edge): all entries not busy; ex_ordertype/ex_vj/ex_vk/ex_A/ex_pc = 0; stage-valid = 0; out_valid/out_tag/out_value/out_jumppc = 0. rs_full = 0 after reset.
- rs_full = 1 iff all RS_SIZE entries are busy, from registered state only. An entry freed by dispatch this cycle is not reusable until the next cycle.
- Issue:
  - If issue_valid && !rs_full, write into the lowest-index free entry.
  - If issue_qj_valid and the tag matches a broadcast visible this cycle (cdb_* or out_*), store the broadcast value and mark the operand ready; same for qk.
  - issue_valid while rs_full is dropped silently; the issuer must not assert it.
- Wake-up: each cycle, every busy entry with a pending operand whose tag equals cdb_tag (cdb_valid) or out_tag (out_valid) takes that value and clears its pending bit. Both buses may match different operands in the same cycle.
- Select:
  - Choose the lowest-index busy entry with both operands ready, using registered state. Wake-ups land the next cycle.
  - On the edge, load ex_* from that entry, set stage-valid=1 and stage-tag=dest, and free the entry.
  - If none is ready, stage-valid=0 and the ex_* registers hold their old values.
- Result: one cycle after dispatch, out_valid=stage-valid, out_tag=stage-tag, out_value=ex_value, out_jumppc=ex_jumppc, all registered. out_valid stays high for exactly one cycle per instruction.
- Latency: issue with both operands ready at edge T → dispatch at edge T+1 → out_valid high after edge T+2. Throughput is 1 instruction/cycle.
- clear_in=1 at an edge:
  - Free all entries and zero stage-valid and out_valid.
  - Issue and dispatch in that cycle are discarded.
  - clear has priority over issue; reset has priority over everything.
- Tags compared at full ROB_W width. No ordering between entries beyond lowest-index select.

Test Plan:
- Reset mid-operation: fill 3 entries, assert rst_n_in=0 for one edge → rs_full=0, out_valid=0, all ex_* = 0, no broadcast afterwards.
- Ready ADD: issue ADD vj=5 vk=7 dest=3 at edge 0 → ex_ordertype=ADD at edge 1; out_valid=1, tag=3, value=12 after edge 2, low after edge 3.
- Dependency chain:
  - Issue ADDI dest=1 (vj=10, A=1), then SUB qj=1 (vk=4) dest=2.
  - SUB wakes from its own broadcast (value 11), then broadcasts tag=2, value=7.
- Same-cycle bypass: issue XOR qj=5 in the cycle cdb_valid=1, cdb_tag=5, cdb_value=0xF0F0; vk=0xFFFF → result 0x0F0F, with no extra wait.
- Full: issue 8 stalled entries (qj=9) → rs_full=1 and a 9th issue is ignored; cdb tag 9 → lowest-index entry dispatches first, and rs_full stays high that edge and drops next.
- Flush: 4 busy entries plus one dispatched, clear_in=1 → no out_valid on following cycles, rs_full=0; JALR vj=0x1001 A=4 pc=0x100 afterwards → value 0x104, jumppc 0x1004.
